// File: rtl/fixed_point_add_pkg.sv
// Shared types and helpers for the fixed-point add unit.
// Used by the bit-serial add sequencer (see SERIAL_ADD_OVF_EN in the top file).
package fixed_point_add_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } serial_add_state_t;

  // Bit counter width: ceil(log2(width)), never narrower than one bit.
  function automatic int serial_add_cnt_w(input int width);
    int w;
    w = $clog2(width);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/serial_add_bit_slice.sv
// One-bit full-add slice; purely combinational.
module serial_add_bit_slice (
  input  logic a,
  input  logic b,
  input  logic carry_in,
  output logic s,
  output logic p,
  output logic g,
  output logic carry_out
);

  // Generate/propagate form of a full adder.
  always_comb begin
    g         = a & b;
    p         = a | b;
    s         = (p & ~g) ^ carry_in;
    carry_out = g | ((p & ~g) & carry_in);
  end

endmodule

// File: rtl/bit_serial_add_sequencer.sv
// Bit-serial adder controller: captures operands, runs one full-add slice
// LSB-first for WIDTH cycles, then holds sum/carry on a valid/ready port.
// Optional: define SERIAL_ADD_OVF_EN to add the registered signed-overflow
// output ovf.
//
// state | meaning
// IDLE  | ready for operands, last result held on c/co
// RUN   | one bit per cycle through the slice
// DONE  | result valid, waiting for out_ready
module bit_serial_add_sequencer
  import fixed_point_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] c,
  output logic             co,
  output logic             busy
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = serial_add_cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  serial_add_state_t state_q, state_d;

  logic [WIDTH-1:0] a_sr, b_sr, r_q, r_next, c_q;
  logic [CNT_W-1:0] cnt_q;
  logic             carry_q, co_q;
  logic             load, step, last;
  logic             slice_s, slice_p, slice_g, slice_co;

  serial_add_bit_slice u_slice (
    .a         (a_sr[0]),
    .b         (b_sr[0]),
    .carry_in  (carry_q),
    .s         (slice_s),
    .p         (slice_p),
    .g         (slice_g),
    .carry_out (slice_co)
  );

  // Sum bit enters at the MSB so the LSB-first result lands in place.
  generate
    if (WIDTH == 1) begin : g_r_w1
      assign r_next = slice_s;
    end else begin : g_r_wn
      assign r_next = {slice_s, r_q[WIDTH-1:1]};
    end
  endgenerate

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state, handshake outputs and datapath enables.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    load      = 1'b0;
    step      = 1'b0;
    last      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt_q == CNT_LAST) begin
          last    = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand shift, carry flop, counter and result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr    <= '0;
      b_sr    <= '0;
      r_q     <= '0;
      c_q     <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      co_q    <= 1'b0;
    end else if (load) begin
      a_sr    <= a;
      b_sr    <= b;
      carry_q <= ci;
      cnt_q   <= '0;
    end else if (step) begin
      a_sr    <= a_sr >> 1;
      b_sr    <= b_sr >> 1;
      r_q     <= r_next;
      carry_q <= slice_g | ((slice_p & ~slice_g) & carry_q);
      cnt_q   <= cnt_q + CNT_W'(1);
      // c/co are separate so they only change when a result completes.
      if (last) begin
        c_q  <= r_next;
        co_q <= slice_co;
      end
    end
  end

  assign c  = c_q;
  assign co = co_q;

`ifdef SERIAL_ADD_OVF_EN
  logic ovf_q;

  // Overflow = carry into MSB xor carry out of MSB, taken on the last bit.
  always_ff @(posedge clk) begin
    if (rst)       ovf_q <= 1'b0;
    else if (last) ovf_q <= carry_q ^ slice_co;
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_bit_serial_add_sequencer.sv
// Directed bench for bit_serial_add_sequencer (WIDTH=8 and WIDTH=1 instances).
module tb_bit_serial_add_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, co, busy, ci = 1'b0;
  logic [7:0] a = '0, b = '0, c;
`ifdef SERIAL_ADD_OVF_EN
  logic       ovf, ovf1;
`endif

  logic       in_valid1 = 1'b0, in_ready1, out_valid1, co1, busy1, ci1 = 1'b0;
  logic [0:0] a1 = '0, b1 = '0, c1;

  int checks = 0;
  int errors = 0;
  int lat;

  always #5 clk = ~clk;

  bit_serial_add_sequencer #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .ci(ci), .out_valid(out_valid), .out_ready(out_ready),
    .c(c), .co(co), .busy(busy)
`ifdef SERIAL_ADD_OVF_EN
    , .ovf(ovf)
`endif
  );

  bit_serial_add_sequencer #(.WIDTH(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .ci(ci1), .out_valid(out_valid1), .out_ready(1'b1),
    .c(c1), .co(co1), .busy(busy1)
`ifdef SERIAL_ADD_OVF_EN
    , .ovf(ovf1)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Accept one operation on the WIDTH=8 instance and wait (bounded) for out_valid.
  task automatic run_op(input logic [7:0] aa, input logic [7:0] bb, input logic cc, output int cycles);
    a = aa; b = bb; ci = cc; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    cycles = 0;
    while (!out_valid && cycles < 40) begin
      tick();
      cycles++;
    end
  endtask

  initial begin
    // Reset state
    tick(); tick();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_c", c, 8'h00);
    check("rst_co", co, 0);
    check("rst_in_ready_w1", in_ready1, 1);
`ifdef SERIAL_ADD_OVF_EN
    check("rst_ovf", ovf, 0);
`endif
    rst = 1'b0;
    tick();

    // 1: latency and basic add
    out_ready = 1'b1;
    a = 8'h0F; b = 8'h01; ci = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("t1_busy_run", busy, 1);
    check("t1_in_ready_run", in_ready, 0);
    lat = 0;
    while (!out_valid && lat < 40) begin tick(); lat++; end
    check("t1_latency", lat, 8);
    check("t1_c", c, 8'h10);
    check("t1_co", co, 0);
    tick();
    check("t1_idle_in_ready", in_ready, 1);
    check("t1_idle_out_valid", out_valid, 0);
    check("t1_idle_c_held", c, 8'h10);

    // 2: carry out
    run_op(8'hFF, 8'h01, 1'b0, lat);
    check("t2a_latency", lat, 8);
    check("t2a_c", c, 8'h00);
    check("t2a_co", co, 1);
    tick();
    run_op(8'hFF, 8'h00, 1'b1, lat);
    check("t2b_c", c, 8'h00);
    check("t2b_co", co, 1);
    tick();
    run_op(8'hA5, 8'h3C, 1'b1, lat);
    check("t2c_c", c, 8'hE2);
    check("t2c_co", co, 0);
    tick();

    // 3: backpressure, ignored second request
    out_ready = 1'b0;
    run_op(8'h12, 8'h34, 1'b0, lat);
    check("t3_latency", lat, 8);
    a = 8'h55; b = 8'h55; ci = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t3_hold_valid", out_valid, 1);
      check("t3_hold_c", c, 8'h46);
      check("t3_hold_co", co, 0);
      check("t3_hold_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    check("t3_idle_out_valid", out_valid, 0);
    check("t3_idle_in_ready", in_ready, 1);
    check("t3_idle_c", c, 8'h46);

    // 4: reset during the 4th RUN cycle
    a = 8'hAA; b = 8'h55; ci = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    check("t4_busy_pre", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t4_out_valid", out_valid, 0);
    check("t4_busy", busy, 0);
    check("t4_in_ready", in_ready, 1);
    check("t4_c", c, 8'h00);
    check("t4_co", co, 0);
    run_op(8'h01, 8'h01, 1'b0, lat);
    check("t4_latency", lat, 8);
    check("t4_c_after", c, 8'h02);
    check("t4_co_after", co, 0);
    tick();

`ifdef SERIAL_ADD_OVF_EN
    // 5: signed overflow
    run_op(8'h7F, 8'h01, 1'b0, lat);
    check("t5a_c", c, 8'h80);
    check("t5a_ovf", ovf, 1);
    check("t5a_co", co, 0);
    tick();
    run_op(8'h80, 8'h80, 1'b0, lat);
    check("t5b_c", c, 8'h00);
    check("t5b_ovf", ovf, 1);
    check("t5b_co", co, 1);
    tick();
    run_op(8'hFF, 8'h01, 1'b0, lat);
    check("t5c_ovf", ovf, 0);
    tick();
`endif

    // 6: WIDTH=1
    a1 = 1'b1; b1 = 1'b1; ci1 = 1'b1; in_valid1 = 1'b1;
    tick();
    in_valid1 = 1'b0;
    check("t6_run_out_valid", out_valid1, 0);
    check("t6_run_busy", busy1, 1);
    tick();
    check("t6_out_valid", out_valid1, 1);
    check("t6_c", c1, 1);
    check("t6_co", co1, 1);
    tick();
    check("t6_idle_in_ready", in_ready1, 1);
    a1 = 1'b1; b1 = 1'b0; ci1 = 1'b0; in_valid1 = 1'b1;
    tick();
    in_valid1 = 1'b0;
    tick();
    check("t6b_out_valid", out_valid1, 1);
    check("t6b_c", c1, 1);
    check("t6b_co", co1, 0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bit_serial_add_sequencer.md
Name: bit_serial_add_sequencer

Overview:
Area-reduced adder controller. It captures two WIDTH-bit operands plus carry-in, then drives a single 1-bit full-add slice LSB-first for WIDTH cycles, holding the carry in a flop between cycles. It presents the WIDTH-bit sum and carry-out on a valid/ready result port. It sits in the FixedPointArithmetic Add unit as the serial, small-footprint alternative to the parallel adders.

Parameters:
WIDTH, 8, operand/result width in bits; legal range is 1 or more.

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  operands valid
in_ready  output  1  sequencer can accept operands
a  input  WIDTH  operand A
b  input  WIDTH  operand B
ci  input  1  carry in
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
c  output  WIDTH  sum
co  output  1  carry out
busy  output  1  state is RUN or DONE
ovf  output  1  signed overflow; present only with SERIAL_ADD_OVF_EN

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values: state IDLE; in_ready=1; out_valid=0; busy=0; c=0; co=0; ovf=0. Internal operand shift registers, bit counter and carry flop are all cleared.
- States:
  - IDLE: in_ready=1. On in_valid&in_ready, load A_sr<=a, B_sr<=b, carry<=ci, cnt<=0, and go to RUN.
  - RUN: in_ready=0, out_valid=0. Each cycle the slice computes:
    - g = A_sr[0] & B_sr[0]
    - p = A_sr[0] | B_sr[0]
    - s = (p & ~g) ^ carry
  - RUN updates per cycle:
    - carry <= g | ((p & ~g) & carry)
    - A_sr and B_sr shift right by 1
    - result register R shifts right with s entering R[WIDTH-1]
    - cnt increments
  - When cnt==WIDTH-1, go to DONE on that same edge.
  - DONE: out_valid=1; c=R; co=carry. Outputs stay stable while out_ready=0. On out_valid&out_ready, go to IDLE.
- Latency: out_valid rises WIDTH cycles after the accepting edge.
- Throughput: one operation per WIDTH+2 cycles at best. There is no overlap between accepting a new operand and holding a result.
- Counter width is $clog2(WIDTH) with a minimum of 1. For WIDTH=1, RUN lasts exactly one cycle.
- c and co are registered and hold their last value in IDLE. Consumers qualify them only with out_valid.
- Operand inputs a, b and ci are ignored outside the IDLE accept edge. in_valid asserted during RUN or DONE has no effect.
- Reset asserted in any state, including mid-RUN or in DONE with the result unconsumed, aborts the operation and applies the reset values on that edge. The result is discarded.
- busy = (state != IDLE).

Optional Feature:
SERIAL_ADD_OVF_EN
- Defined:
  - The ovf port exists.
  - On the final RUN cycle, register ovf <= carry_into_msb ^ carry_out_of_msb. This is the carry flop value before and after the MSB update.
  - ovf is valid with out_valid, held in DONE, and cleared by reset.
- Undefined: the ovf port and its logic are absent. All other behaviour is unchanged.

Decomposition:
- Package fixed_point_add_pkg holds:
  - typedef enum logic [1:0] {IDLE, RUN, DONE} serial_add_state_t
  - a function serial_add_cnt_w(WIDTH) returning the counter width
- Sub-module serial_add_bit_slice (combinational) takes a, b and carry_in. It outputs s, p, g and carry_out.
- The sequencer owns all flops: the carry flop, shift registers, counter and FSM.

Test Plan:
1. WIDTH=8: a=0x0F, b=0x01, ci=0, out_ready=1 -> out_valid exactly 8 cycles after accept; c=0x10, co=0; back to IDLE next cycle with in_ready=1.
2. a=0xFF, b=0x01, ci=0 -> c=0x00, co=1. Also a=0xFF, b=0x00, ci=1 -> c=0x00, co=1.
3. Backpressure: a=0x12, b=0x34, out_ready=0 for 5 cycles after out_valid -> c=0x46, co=0 held stable; in_ready=0 throughout. A second in_valid with a=0x55 is ignored. One handshake then returns to IDLE.
4. Reset mid-RUN: assert rst on the 4th RUN cycle -> next cycle state IDLE, out_valid=0, busy=0, in_ready=1, c=0, co=0. A fresh 0x01+0x01 then yields c=0x02.
5. SERIAL_ADD_OVF_EN: 0x7F+0x01 -> c=0x80, ovf=1, co=0. 0x80+0x80 -> c=0x00, ovf=1, co=1. 0xFF+0x01 -> ovf=0.
6. WIDTH=1: a=1, b=1, ci=1 -> out_valid 1 cycle after accept; c=1, co=1.
